// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - requester/adder handshake and operand/result bundle
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Requester side: issues start with operands, observes status and result.
  modport master (
    output start, a_in, b_in,
    input  busy, done, sum, cout
  );

  // Adder side: accepts operands, reports status and result.
  modport slave (
    input  start, a_in, b_in,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sharing one full-adder cell over WIDTH cycles
module half_adder_structural (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  xor g_sum   (s, a, b);
  and g_carry (c, a, b);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_adder_ctrl_if.slave   bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             cy;
  logic [CW-1:0]    cnt;

  logic             ha0_s;
  logic             ha0_c;
  logic             ha1_c;
  logic             bit_s;
  logic             bit_c;
  logic             last_bit;
  logic             accept;

  // The single shared full-adder cell: two half adders plus an OR for carry.
  half_adder_structural u_ha0 (.a(a_sr[0]), .b(b_sr[0]), .s(ha0_s), .c(ha0_c));
  half_adder_structural u_ha1 (.a(ha0_s),   .b(cy),      .s(bit_s), .c(ha1_c));
  assign bit_c = ha0_c | ha1_c;

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign accept   = (state == S_IDLE) && bus.start;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: IDLE -> RUN on start, RUN -> DONE after the MSB, DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_RUN;
      S_RUN:   if (last_bit)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, LSB-first shifting, carry flop and result latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      s_sr   <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      cy     <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr <= bus.a_in;
      b_sr <= bus.b_in;
      cy   <= 1'b0;
      cnt  <= '0;
    end else if (state == S_RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      s_sr <= {bit_s, s_sr[WIDTH-1:1]};
      cy   <= bit_c;
      if (last_bit) begin
        // Result registers only change here, so the previous result stays visible during RUN.
        sum_q  <= {bit_s, s_sr[WIDTH-1:1]};
        cout_q <= bit_c;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.done = (state == S_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed self-checking bench for serial_adder_ctrl
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands with start, return at the sample point just after the accepting edge.
  task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a_in  = 8'h3C;
    bus.b_in  = 8'hC3;
    chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
  endtask

  // Wait (bounded) for done counting from sample point k0; check latency, hold and one-cycle pulse.
  task automatic wait_done(input string tag, input int k0, input logic [W:0] exp, input logic [W:0] prev);
    int   k;
    logic held_ok;
    logic seen;
    k       = k0;
    held_ok = 1'b1;
    seen    = 1'b0;
    while (k < 30 && !seen) begin
      @(negedge clk);
      k++;
      if (bus.done) seen = 1'b1;
      else if ({bus.cout, bus.sum} !== prev) held_ok = 1'b0;
    end
    chk({tag, "_seen"},    {31'd0, seen}, 32'd1);
    chk({tag, "_latency"}, k, W);
    chk({tag, "_held"},    {31'd0, held_ok}, 32'd1);
    chk({tag, "_result"},  {23'd0, bus.cout, bus.sum}, {23'd0, exp});
    chk({tag, "_busy"},    {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    chk({tag, "_pulse"},   {31'd0, bus.done}, 32'd0);
    chk({tag, "_idle"},    {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int           ndone;
    int           cyc;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W:0]   rexp;

    // Reset held two cycles.
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_sum",  {24'd0, bus.sum},  32'h00);
    chk("rst_cout", {31'd0, bus.cout}, 32'd0);
    rst = 1'b0;

    // Basic operation and result hold between operations.
    accept_op(8'h01, 8'h01);
    wait_done("op_01_01", 0, 9'h002, 9'h000);
    accept_op(8'hFF, 8'h01);
    wait_done("op_ff_01", 0, 9'h100, 9'h002);
    accept_op(8'hA5, 8'h5A);
    wait_done("op_a5_5a", 0, 9'h0FF, 9'h100);

    // Start pulsed mid-RUN is ignored and not queued.
    accept_op(8'hA5, 8'h5A);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = 8'h10;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignore_start", 4, 9'h0FF, 9'h0FF);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("ignore_no_extra_done", ndone, 0);

    // Reset mid-RUN aborts without done and clears the result.
    accept_op(8'h33, 8'h44);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_sum",  {24'd0, bus.sum},  32'h00);
    chk("abort_cout", {31'd0, bus.cout}, 32'd0);
    rst   = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    accept_op(8'h80, 8'h80);
    wait_done("op_80_80", 0, 9'h100, 9'h000);

    // Back-to-back operations with start held high.
    @(negedge clk);
    ra        = W'($urandom_range(0, 255));
    rb        = W'($urandom_range(0, 255));
    rexp      = {1'b0, ra} + {1'b0, rb};
    bus.start = 1'b1;
    bus.a_in  = ra;
    bus.b_in  = rb;
    for (int i = 0; i < 50; i++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!bus.done && cyc < 40);
      chk("b2b_spacing", cyc, (i == 0) ? W + 1 : W + 2);
      chk("b2b_result", {23'd0, bus.cout, bus.sum}, {23'd0, rexp});
      ra       = W'($urandom_range(0, 255));
      rb       = W'($urandom_range(0, 255));
      rexp     = {1'b0, ra} + {1'b0, rb};
      bus.a_in = ra;
      bus.b_in = rb;
      if (i == 49) bus.start = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("final_idle", {31'd0, bus.busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
